// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the MIPS core: word width and the
// EX-stage forwarding select encodings.
package pipe_pkg;

  localparam int WORD_W     = 32;
  localparam int FWD_NUM_IN = 3;

  typedef enum logic [1:0] {
    FWD_SEL_REG = 2'd0,
    FWD_SEL_WB  = 2'd1,
    FWD_SEL_MEM = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment on the
// same edge leaves a count of one so the new event is not lost.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fwd_mux_reg.sv
// EX-stage forwarding operand mux with a registered output, stall/flush
// handling and reporting of out-of-range selects.
module fwd_mux_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter int NUM_IN    = FWD_NUM_IN,
  parameter int SEL_W     = $clog2(NUM_IN),
  parameter int ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    sel_err,
  output logic [ERR_CNT_W-1:0]    err_count
);

  logic [WIDTH-1:0] sel_word;
  logic             sel_legal;
  logic             take;
  logic             err_accept;

  // Explicit compare per input so an unused select code yields zero, never X.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_word = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_legal  = ({1'b0, sel} < (SEL_W+1)'(NUM_IN));
  assign take       = !flush && !stall && in_valid;
  assign err_accept = take && !sel_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (in_valid && sel_legal) begin
        out_data  <= sel_word;
        out_valid <= 1'b1;
      end else if (in_valid) begin
        out_data  <= '0;
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // A new error on the same edge as a clear wins, so the flag stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (err_accept) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (err_clr),
    .inc   (err_accept),
    .count (err_count)
  );

endmodule

// File: tb/tb_fwd_mux_reg.sv
// Scoreboard bench for fwd_mux_reg: three parameterisations share control
// inputs; each expectation names the instance it applies to.
module tb_fwd_mux_reg;
  import pipe_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [1:0]   sel;
  logic         in_valid;
  logic         stall;
  logic         flush;
  logic         err_clr;
  logic [95:0]  bus3;
  logic [255:0] bus4;

  logic [31:0]  a_data;
  logic         a_valid;
  logic         a_err;
  logic [7:0]   a_cnt;
  logic [31:0]  b_data;
  logic         b_valid;
  logic         b_err;
  logic [1:0]   b_cnt;
  logic [63:0]  c_data;
  logic         c_valid;
  logic         c_err;
  logic [7:0]   c_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          dut;
    logic [63:0] data;
    logic        valid;
    logic        err;
    logic [7:0]  cnt;
    string       name;
  } exp_t;

  exp_t q[$];

  fwd_mux_reg #(.WIDTH(32), .NUM_IN(3), .ERR_CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in_bus(bus3), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .out_data(a_data), .out_valid(a_valid), .sel_err(a_err), .err_count(a_cnt)
  );

  fwd_mux_reg #(.WIDTH(32), .NUM_IN(3), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in_bus(bus3), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .out_data(b_data), .out_valid(b_valid), .sel_err(b_err), .err_count(b_cnt)
  );

  fwd_mux_reg #(.WIDTH(64), .NUM_IN(4), .ERR_CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in_bus(bus4), .in_valid(in_valid),
    .stall(stall), .flush(flush), .err_clr(err_clr),
    .out_data(c_data), .out_valid(c_valid), .sel_err(c_err), .err_count(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [255:0] mk3(input logic [31:0] w0, input logic [31:0] w1,
                                       input logic [31:0] w2);
    return {160'b0, w2, w1, w0};
  endfunction

  task automatic checkOutput(input string name,
                             input logic [63:0] ad, input logic av, input logic ae,
                             input logic [7:0] ac,
                             input logic [63:0] ed, input logic ev, input logic ee,
                             input logic [7:0] ec);
    tests++;
    if ({ad, av, ae, ac} !== {ed, ev, ee, ec}) begin
      fails++;
      $display("[TB] FAIL %s: got data=%h valid=%b err=%b cnt=%0d, expected data=%h valid=%b err=%b cnt=%0d",
               name, ad, av, ae, ac, ed, ev, ee, ec);
    end
  endtask

  task automatic applyStimulus(input int dut, input logic [1:0] s, input logic v,
                               input logic st, input logic fl, input logic cl,
                               input logic [255:0] b,
                               input logic [63:0] ed, input logic ev, input logic ee,
                               input logic [7:0] ec, input string name);
    exp_t e;
    @(negedge clk);
    sel      = s;
    in_valid = v;
    stall    = st;
    flush    = fl;
    err_clr  = cl;
    bus3     = b[95:0];
    bus4     = b;
    e.dut    = dut;
    e.data   = ed;
    e.valid  = ev;
    e.err    = ee;
    e.cnt    = ec;
    e.name   = name;
    q.push_back(e);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n    = 1'b0;
    sel      = '0;
    in_valid = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    err_clr  = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: each edge that has a pending expectation is checked 1 unit later.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      case (e.dut)
        0: checkOutput(e.name, {32'b0, a_data}, a_valid, a_err, a_cnt,
                       e.data, e.valid, e.err, e.cnt);
        1: checkOutput(e.name, {32'b0, b_data}, b_valid, b_err, {6'b0, b_cnt},
                       e.data, e.valid, e.err, e.cnt);
        default: checkOutput(e.name, c_data, c_valid, c_err, c_cnt,
                             e.data, e.valid, e.err, e.cnt);
      endcase
    end
  end

  initial begin
    logic [63:0]  w[4];
    logic [63:0]  md;
    logic         mv;
    logic [1:0]   s;
    logic         v, st, fl, cl;
    logic [255:0] b;

    rst_n = 1'b0;
    bus3  = '0;
    bus4  = '0;
    doReset();

    // Reset mid-stream, then first edge after release
    applyStimulus(0, 2'd3, 1, 0, 0, 0, mk3(0, 0, 0), 64'h0, 0, 1, 8'd1, "t1_illegal");
    applyStimulus(0, FWD_SEL_WB, 1, 0, 0, 0, mk3(0, 32'h1234, 0), 64'h1234, 1, 1, 8'd1, "t1_load");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("t1_async_reset", {32'b0, a_data}, a_valid, a_err, a_cnt, 64'h0, 0, 0, 8'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(0, FWD_SEL_MEM, 1, 0, 0, 0, mk3(0, 0, 32'hDEADBEEF),
                  64'hDEADBEEF, 1, 0, 8'd0, "t1_after_release");

    // Sweep all legal selects
    applyStimulus(0, FWD_SEL_REG, 1, 0, 0, 0, mk3(32'h11, 32'h22, 32'h33), 64'h11, 1, 0, 8'd0, "t2_sel0");
    applyStimulus(0, FWD_SEL_WB,  1, 0, 0, 0, mk3(32'h11, 32'h22, 32'h33), 64'h22, 1, 0, 8'd0, "t2_sel1");
    applyStimulus(0, FWD_SEL_MEM, 1, 0, 0, 0, mk3(32'h11, 32'h22, 32'h33), 64'h33, 1, 0, 8'd0, "t2_sel2");

    // Stall holds everything (even an illegal select); flush beats stall
    applyStimulus(0, 2'd0, 1, 0, 0, 0, mk3(32'hA5A5A5A5, 32'h22, 32'h33), 64'hA5A5A5A5, 1, 0, 8'd0, "t3_load");
    applyStimulus(0, 2'd1, 1, 1, 0, 0, mk3(1, 2, 3), 64'hA5A5A5A5, 1, 0, 8'd0, "t3_stall1");
    applyStimulus(0, 2'd2, 1, 1, 0, 0, mk3(4, 5, 6), 64'hA5A5A5A5, 1, 0, 8'd0, "t3_stall2");
    applyStimulus(0, 2'd3, 1, 1, 0, 0, mk3(7, 8, 9), 64'hA5A5A5A5, 1, 0, 8'd0, "t3_stall3");
    applyStimulus(0, 2'd1, 1, 1, 1, 0, mk3(7, 8, 9), 64'h0, 0, 0, 8'd0, "t3_flush_stall");

    // Illegal selects, ignored when unqualified or flushed, cleared during stall
    applyStimulus(0, 2'd3, 1, 0, 0, 0, mk3(7, 8, 9), 64'h0, 0, 1, 8'd1, "t4_illegal1");
    applyStimulus(0, 2'd3, 1, 0, 0, 0, mk3(7, 8, 9), 64'h0, 0, 1, 8'd2, "t4_illegal2");
    applyStimulus(0, 2'd3, 0, 0, 0, 0, mk3(7, 8, 9), 64'h0, 0, 1, 8'd2, "t4_illegal_novalid");
    applyStimulus(0, 2'd1, 1, 0, 0, 0, mk3(32'h11, 32'h22, 32'h33), 64'h22, 1, 1, 8'd2, "t4_legal");
    applyStimulus(0, 2'd0, 0, 0, 0, 0, mk3(32'h11, 32'h22, 32'h33), 64'h22, 0, 1, 8'd2, "t4_invalid_hold");
    applyStimulus(0, 2'd3, 1, 0, 1, 0, mk3(32'h11, 32'h22, 32'h33), 64'h0, 0, 1, 8'd2, "t4_flush_illegal");
    applyStimulus(0, 2'd3, 1, 1, 0, 1, mk3(32'h11, 32'h22, 32'h33), 64'h0, 0, 0, 8'd0, "t4_clr_in_stall");
    applyStimulus(0, 2'd3, 1, 0, 0, 1, mk3(32'h11, 32'h22, 32'h33), 64'h0, 0, 1, 8'd1, "t4_clr_with_err");

    // Saturation with a 2-bit counter
    doReset();
    applyStimulus(1, 2'd3, 1, 0, 0, 0, mk3(0, 0, 0), 64'h0, 0, 1, 8'd1, "t5_err1");
    applyStimulus(1, 2'd3, 1, 0, 0, 0, mk3(0, 0, 0), 64'h0, 0, 1, 8'd2, "t5_err2");
    applyStimulus(1, 2'd3, 1, 0, 0, 0, mk3(0, 0, 0), 64'h0, 0, 1, 8'd3, "t5_err3");
    applyStimulus(1, 2'd3, 1, 0, 0, 0, mk3(0, 0, 0), 64'h0, 0, 1, 8'd3, "t5_sat4");
    applyStimulus(1, 2'd3, 1, 0, 0, 0, mk3(0, 0, 0), 64'h0, 0, 1, 8'd3, "t5_sat5");
    applyStimulus(1, 2'd3, 1, 0, 0, 1, mk3(0, 0, 0), 64'h0, 0, 1, 8'd1, "t5_clr_with_err");
    applyStimulus(1, 2'd0, 0, 0, 0, 1, mk3(0, 0, 0), 64'h0, 0, 0, 8'd0, "t5_clr_alone");
    applyStimulus(1, 2'd2, 1, 0, 0, 0, mk3(0, 0, 32'h33), 64'h33, 1, 0, 8'd0, "t5_legal");

    // Four 64-bit inputs: every code legal, checked against a reference model
    doReset();
    md = '0;
    mv = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < 4; k++) w[k] = {$urandom, $urandom};
      b  = {w[3], w[2], w[1], w[0]};
      s  = 2'($urandom_range(0, 3));
      v  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 15) == 0);
      cl = ($urandom_range(0, 7) == 0);
      if (fl) begin
        md = '0;
        mv = 1'b0;
      end else if (!st) begin
        if (v) begin
          md = w[s];
          mv = 1'b1;
        end else begin
          mv = 1'b0;
        end
      end
      applyStimulus(2, s, v, st, fl, cl, b, md, mv, 0, 8'd0, "t6_random");
    end

    repeat (2) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
